// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receiver and transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // XOR over data bits plus parity bit that a correctly formed frame yields
    function automatic logic par_target(input int parity);
        return (parity == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small synchronous FIFO holding received words for the host.
// Latency: push visible at head one cycle later; head shows next entry one cycle after a pop.
// Backpressure: push when full is dropped unless a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];

    // storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver, configurable data width, parity and stop bits.
// Latency: word and flags appear on the rxclk edge closing the tick that samples the last stop bit.
// Backpressure: none toward the line; host acks with rdy_clr, unread words are dropped and flag overrun.
// Optional macro UART_RX_FIFO_EN: buffer FIFO_DEPTH words in uart_rx_fifo instead of one register.
module uart_rx_core #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 i_rxclk,
    input  logic                 i_rst,
    input  logic                 i_rxclken,
    input  logic                 i_rx,
    input  logic                 i_rdy_clr,
    output logic [DATA_BITS-1:0] o_dout,
    output logic                 o_rdy,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_overrun
);
    import uart_pkg::*;

    localparam int               CNT_W      = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0]       DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic             PAR_TARGET = par_target(PARITY);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_core: DATA_BITS must be 5..9");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_rx_core: OVERSAMPLE must be even and >= 8");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
        $error("uart_rx_core: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_rx_core: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("uart_rx_core: FIFO_DEPTH must be a power of 2, >= 2");
    end

    logic                 r_rx_meta;
    logic                 r_rx_sync;
    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [3:0]           r_bit_cnt;
    logic [3:0]           w_bit_cnt_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 r_perr;
    logic                 w_perr_nxt;
    logic                 r_ferr;
    logic                 w_ferr_nxt;
    logic                 r_armed;
    logic                 w_armed_nxt;
    logic                 w_commit;
    logic                 w_commit_ferr;

    // two-flop synchroniser for the asynchronous rx pad; idles high
    always_ff @(posedge i_rxclk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // frame FSM state, sample counter, shifter and per-frame error flags
    always_ff @(posedge i_rxclk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_perr    <= w_perr_nxt;
            r_ferr    <= w_ferr_nxt;
            r_armed   <= w_armed_nxt;
        end
    end

    // next-state logic; everything advances only on baud ticks. r_armed blocks a new
    // start until the line has been seen high, so a held break yields a single word.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_perr_nxt    = r_perr;
        w_ferr_nxt    = r_ferr;
        w_armed_nxt   = r_armed;
        w_commit      = 1'b0;
        w_commit_ferr = r_ferr;
        if (i_rxclken) begin
            unique case (r_state)
                IDLE: begin
                    if (r_rx_sync) begin
                        w_armed_nxt = 1'b1;
                    end else if (r_armed) begin
                        w_state_nxt = START;
                        w_cnt_nxt   = '0;
                        w_armed_nxt = 1'b0;
                    end
                end
                START: begin
                    if (r_cnt == CNT_MID) begin
                        if (r_rx_sync) begin
                            // too short to be a start bit; line is high again
                            w_state_nxt = IDLE;
                            w_armed_nxt = 1'b1;
                        end else begin
                            w_state_nxt   = DATA;
                            w_cnt_nxt     = '0;
                            w_bit_cnt_nxt = '0;
                            w_perr_nxt    = 1'b0;
                            w_ferr_nxt    = 1'b0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_nxt   = '0;
                        w_shift_nxt = {r_rx_sync, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == DATA_LAST) begin
                            w_bit_cnt_nxt = '0;
                            w_state_nxt   = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                uart_pkg::PARITY: begin
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_nxt   = '0;
                        w_perr_nxt  = (((^r_shift) ^ r_rx_sync) != PAR_TARGET);
                        w_state_nxt = STOP;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_nxt     = '0;
                        w_commit_ferr = r_ferr | ~r_rx_sync;
                        w_ferr_nxt    = w_commit_ferr;
                        if (r_bit_cnt == STOP_LAST) begin
                            w_bit_cnt_nxt = '0;
                            w_commit      = 1'b1;
                            w_state_nxt   = IDLE;
                            w_armed_nxt   = ~w_commit_ferr;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    localparam int ENT_W = DATA_BITS + 2;

    logic [ENT_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             r_overrun;

    assign w_pop = i_rdy_clr & ~w_empty;

    uart_rx_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_rxclk),
        .i_rst      (i_rst),
        .i_push     (w_commit),
        .i_push_dat ({r_perr, w_commit_ferr, r_shift}),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // sticky overrun: set when a word meets a full FIFO with no pop, cleared by any pop
    always_ff @(posedge i_rxclk or posedge i_rst) begin
        if (i_rst) begin
            r_overrun <= 1'b0;
        end else if (w_pop) begin
            r_overrun <= 1'b0;
        end else if (w_commit && w_full) begin
            r_overrun <= 1'b1;
        end
    end

    assign o_dout       = w_head[DATA_BITS-1:0];
    assign o_frame_err  = w_head[DATA_BITS];
    assign o_parity_err = w_head[DATA_BITS+1];
    assign o_rdy        = ~w_empty;
    assign o_overrun    = r_overrun;
`else
    logic [DATA_BITS-1:0] r_dout;
    logic                 r_rdy;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    // single holding register; an ack in the commit cycle frees it for the new word
    always_ff @(posedge i_rxclk or posedge i_rst) begin
        if (i_rst) begin
            r_dout       <= '0;
            r_rdy        <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (w_commit && (!r_rdy || i_rdy_clr)) begin
            r_dout       <= r_shift;
            r_frame_err  <= w_commit_ferr;
            r_parity_err <= r_perr;
            r_rdy        <= 1'b1;
            if (r_rdy && i_rdy_clr) begin
                r_overrun <= 1'b0;
            end
        end else if (w_commit) begin
            r_overrun <= 1'b1;
        end else if (i_rdy_clr && r_rdy) begin
            r_rdy     <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign o_dout       = r_dout;
    assign o_frame_err  = r_frame_err;
    assign o_parity_err = r_parity_err;
    assign o_rdy        = r_rdy;
    assign o_overrun    = r_overrun;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed plus randomized frames on an 8N1 instance and a 7E2 instance.
// Latency: n/a.
// Backpressure: host acks driven by the bench.
module tb_uart_rx_core;

    localparam int OS = 16;
`ifdef UART_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
    } word_t;

    logic       clk;
    logic       rst;
    logic       rxclken;
    logic       rx0, rx1, clr0, clr1;
    logic [7:0] dout0;
    logic       rdy0, fe0, pe0, ov0;
    logic [6:0] dout1;
    logic       rdy1, fe1, pe1, ov1;

    int errors   = 0;
    int checks   = 0;
    int tick_div = 1;

    // expected contents of the 8N1 receiver's output buffer
    word_t q[$];
    logic  m_ovr = 1'b0;

    uart_rx_core #(
        .DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_dut0 (
        .i_rxclk(clk), .i_rst(rst), .i_rxclken(rxclken), .i_rx(rx0), .i_rdy_clr(clr0),
        .o_dout(dout0), .o_rdy(rdy0), .o_frame_err(fe0), .o_parity_err(pe0), .o_overrun(ov0)
    );

    uart_rx_core #(
        .DATA_BITS(7), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(2)
    ) u_dut1 (
        .i_rxclk(clk), .i_rst(rst), .i_rxclken(rxclken), .i_rx(rx1), .i_rdy_clr(clr1),
        .o_dout(dout1), .o_rdy(rdy1), .o_frame_err(fe1), .o_parity_err(pe1), .o_overrun(ov1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // baud tick: one cycle in every tick_div
    initial begin : tick_gen
        int tc;
        tc = 0;
        rxclken = 1'b0;
        forever begin
            @(negedge clk);
            tc = tc + 1;
            if (tc >= tick_div) tc = 0;
            rxclken = (tc == 0);
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_commit(input logic [7:0] d, input logic fe);
        word_t w;
        w.d  = d;
        w.fe = fe;
        if (q.size() < CAP) q.push_back(w);
        else m_ovr = 1'b1;
    endfunction

    task automatic drive_bit(input int sel, input logic b);
        if (sel == 0) rx0 = b;
        else rx1 = b;
        repeat (OS * tick_div) @(negedge clk);
    endtask

    task automatic send0(input logic [7:0] d, input logic stop);
        drive_bit(0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(0, d[i]);
        drive_bit(0, stop);
        m_commit(d, ~stop);
    endtask

    task automatic pop0();
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        if (q.size() != 0) begin
            q.delete(0);
            m_ovr = 1'b0;
        end
    endtask

    task automatic check0(input string tag);
        chk({tag, " rdy"}, 32'(rdy0), 32'(q.size() != 0));
        chk({tag, " overrun"}, 32'(ov0), 32'(m_ovr));
        chk({tag, " parity_err"}, 32'(pe0), 32'd0);
        if (q.size() != 0) begin
            chk({tag, " dout"}, 32'(dout0), 32'(q[0].d));
            chk({tag, " frame_err"}, 32'(fe0), 32'(q[0].fe));
        end
    endtask

    // 7 data bits, even parity, two stop bits, followed by one idle bit
    task automatic send1(input logic [6:0] d, input logic pb, input logic s1, input logic s2,
                         input string tag);
        logic exp_pe;
        logic exp_fe;
        drive_bit(1, 1'b0);
        for (int i = 0; i < 7; i++) drive_bit(1, d[i]);
        drive_bit(1, pb);
        drive_bit(1, s1);
        drive_bit(1, s2);
        drive_bit(1, 1'b1);
        exp_pe = (((^d) ^ pb) != 1'b0);
        exp_fe = !(s1 && s2);
        chk({tag, " rdy"}, 32'(rdy1), 32'd1);
        chk({tag, " dout"}, 32'(dout1), 32'(d));
        chk({tag, " parity_err"}, 32'(pe1), 32'(exp_pe));
        chk({tag, " frame_err"}, 32'(fe1), 32'(exp_fe));
        chk({tag, " overrun"}, 32'(ov1), 32'd0);
        clr1 = 1'b1;
        @(negedge clk);
        clr1 = 1'b0;
        chk({tag, " rdy after clr"}, 32'(rdy1), 32'd0);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        rx0  = 1'b1;
        rx1  = 1'b1;
        clr0 = 1'b0;
        clr1 = 1'b0;
        repeat (3) @(negedge clk);
        q.delete();
        m_ovr = 1'b0;
        chk("reset rdy0", 32'(rdy0), 32'd0);
        chk("reset dout0", 32'(dout0), 32'd0);
        chk("reset flags0", 32'({fe0, pe0, ov0}), 32'd0);
        chk("reset rdy1", 32'(rdy1), 32'd0);
        rst = 1'b0;
        repeat (2 * OS * tick_div) @(negedge clk);
    endtask

    // first-word latency, ack, and reset in the middle of a frame
    task automatic run_basic(input int td);
        int lat;
        int lo;
        int hi;
        tick_div = td;
        do_reset();
        lat = 0;
        lo  = 148 * td;
        hi  = 160 * td;
        fork
            send0(8'hA5, 1'b1);
            begin
                while (!rdy0 && lat < 200 * td) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        checks++;
        assert (lat >= lo && lat <= hi) else begin
            errors++;
            $error("FAIL t1 latency: observed=%0d expected=%0d..%0d", lat, lo, hi);
        end
        check0("t1 A5");
        pop0();
        check0("t1 after clr");

        send0(8'h33, 1'b1);
        check0("t6 pending");
        drive_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(0, 1'b1);
        rx0 = 1'b1;
        repeat (OS * td / 2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6 async rdy", 32'(rdy0), 32'd0);
        chk("t6 async dout", 32'(dout0), 32'd0);
        chk("t6 async flags", 32'({fe0, pe0, ov0}), 32'd0);
        q.delete();
        m_ovr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * OS * td) @(negedge clk);
        check0("t6 after reset");
        send0(8'h81, 1'b1);
        check0("t6 81");
        pop0();
        check0("t6 after clr");
    endtask

    initial begin : main
        run_basic(1);

        tick_div = 1;
        do_reset();
        rx0 = 1'b0;
        repeat (4 * tick_div) @(negedge clk);
        rx0 = 1'b1;
        repeat (2 * OS * tick_div) @(negedge clk);
        check0("t2 glitch");
        chk("t2 glitch flags", 32'({fe0, pe0}), 32'd0);
        send0(8'h5A, 1'b1);
        check0("t2 5A");
        pop0();

        send0(8'h3C, 1'b0);
        repeat (40 * OS * tick_div) @(negedge clk);
        check0("t3 break");
        pop0();
        check0("t3 single word");
        rx0 = 1'b1;
        repeat (2 * OS * tick_div) @(negedge clk);
        send0(8'h11, 1'b1);
        check0("t3 11");
        pop0();

        send0(8'h12, 1'b1);
        send0(8'h34, 1'b1);
        check0("t5 two frames");
        while (q.size() != 0) begin
            pop0();
            check0("t5 drain two");
        end
        for (int k = 1; k <= 5; k++) send0(8'(k), 1'b1);
        check0("t5 five frames");
        while (q.size() != 0) begin
            pop0();
            check0("t5 drain five");
        end

        send1(7'h07, 1'b0, 1'b1, 1'b1, "t4 bad parity");
        send1(7'h07, 1'b1, 1'b1, 1'b1, "t4 good parity");

        for (int k = 0; k < 6; k++) begin
            logic [7:0] d;
            logic       stop;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send0(d, stop);
            drive_bit(0, 1'b1);
            check0("rand8");
            pop0();
            check0("rand8 clr");
        end
        for (int k = 0; k < 6; k++) begin
            logic [6:0] d;
            logic       pb, s1, s2;
            d  = 7'($urandom_range(0, 127));
            pb = 1'($urandom_range(0, 1));
            s1 = ($urandom_range(0, 3) != 0);
            s2 = ($urandom_range(0, 3) != 0);
            send1(d, pb, s1, s2, "rand7e2");
        end

        run_basic(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
